// File: rtl/clk_rst_pkg.sv
// clk_rst_pkg: shared state encoding and clock-enable counter width for clk_rst_mgr.
package clk_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        PLL_RST   = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int CE_CNT_W = 16;

endpackage

// File: rtl/clk_rst_ce_div.sv
// clk_rst_ce_div: one clock-enable channel, a one-cycle ce pulse every DIV cycles while run is high.
module clk_rst_ce_div
    import clk_rst_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic ce
);

    localparam logic [CE_CNT_W-1:0] LAST = CE_CNT_W'(DIV - 1);

    logic [CE_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ce  <= 1'b0;
        end else if (!run) begin
            cnt <= '0;
            ce  <= 1'b0;
        end else begin
            ce  <= cnt == LAST;
            cnt <= (cnt == LAST) ? '0 : cnt + CE_CNT_W'(1);
        end
    end

endmodule

// File: rtl/clk_rst_mgr.sv
// clk_rst_mgr: PLL lock supervisor with reset sequencing and divided clock enables.
// Optional status counters (retry_cnt, lost_cnt) are built when CLK_RST_MGR_STATUS_EN is defined.
module clk_rst_mgr
    import clk_rst_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int NUM_CE              = 3,
    parameter int CE_DIV_BASE         = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic              sys_rst_n,
    output logic [NUM_CE-1:0] ce,
    output logic [1:0]        state_o,
    output logic              lock_lost
`ifdef CLK_RST_MGR_STATUS_EN
    ,
    output logic [7:0]        retry_cnt,
    output logic [7:0]        lost_cnt
`endif
);

    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int PW = $clog2(PLL_RST_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST = PW'(PLL_RST_CYCLES - 1);

    state_t        state, state_nx;
    logic          lock_m, lock_s;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic [SW-1:0] scnt, scnt_nx;
    logic [PW-1:0] pcnt, pcnt_nx;
    logic          run, lost;

    // Counters not owned by the current state fall back to zero, so every entry starts clean.
    always_comb begin
        state_nx = state;
        tcnt_nx  = '0;
        scnt_nx  = '0;
        pcnt_nx  = '0;
        case (state)
            WAIT_LOCK: begin
                tcnt_nx = tcnt + TW'(1);
                if (lock_s) begin
                    state_nx = STABILIZE;
                    tcnt_nx  = '0;
                end else if (tcnt == T_LAST) begin
                    state_nx = PLL_RST;
                    tcnt_nx  = '0;
                end
            end
            PLL_RST: begin
                pcnt_nx = pcnt + PW'(1);
                if (pcnt == P_LAST) begin
                    state_nx = WAIT_LOCK;
                    pcnt_nx  = '0;
                end
            end
            STABILIZE: begin
                scnt_nx = scnt + SW'(1);
                if (!lock_s) begin
                    state_nx = WAIT_LOCK;
                    scnt_nx  = '0;
                end else if (scnt == S_LAST) begin
                    state_nx = RUN;
                    scnt_nx  = '0;
                end
            end
            RUN:     state_nx = lock_s ? RUN : WAIT_LOCK;
            default: state_nx = WAIT_LOCK;
        endcase
    end

    // Dividers count only while RUN persists, so they start one edge after entry and stop on the exit edge.
    assign run     = (state == RUN) && lock_s;
    assign lost    = (state == RUN) && !lock_s;
    assign state_o = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m    <= 1'b0;
            lock_s    <= 1'b0;
            state     <= WAIT_LOCK;
            tcnt      <= '0;
            scnt      <= '0;
            pcnt      <= '0;
            sys_rst_n <= 1'b0;
            pll_reset <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            lock_m    <= pll_lock;
            lock_s    <= lock_m;
            state     <= state_nx;
            tcnt      <= tcnt_nx;
            scnt      <= scnt_nx;
            pcnt      <= pcnt_nx;
            sys_rst_n <= state_nx == RUN;
            pll_reset <= state_nx == PLL_RST;
            lock_lost <= lost;
        end
    end

`ifdef CLK_RST_MGR_STATUS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt <= '0;
            lost_cnt  <= '0;
        end else begin
            if (state == WAIT_LOCK && state_nx == PLL_RST && retry_cnt != 8'hFF)
                retry_cnt <= retry_cnt + 8'd1;
            if (lost && lost_cnt != 8'hFF)
                lost_cnt <= lost_cnt + 8'd1;
        end
    end
`endif

    for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
        clk_rst_ce_div #(
            .DIV(CE_DIV_BASE << i)
        ) u_div (
            .clk  (clk),
            .rst_n(rst_n),
            .run  (run),
            .ce   (ce[i])
        );
    end

endmodule

// File: doc/clk_rst_mgr.md
CLK_RST_MGR -- requirements
Module: clk_rst_mgr

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synced-lock cycles required before reset release (>=1).
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: cycles waiting for lock before a PLL reset retry (>=2).
REQ-003 SHALL have parameter PLL_RST_CYCLES, default 16: pll_reset pulse width in cycles (>=1).
REQ-004 SHALL have parameter NUM_CE, default 3: number of clock-enable channels (1..8).
REQ-005 SHALL have parameter CE_DIV_BASE, default 2: divisor of channel 0; channel i divides by CE_DIV_BASE<<i (>=2).
REQ-006 SHALL have port clk, input, 1: free-running reference clock (27 MHz crystal), the only clock.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port pll_lock, input, 1: PLL lock, asynchronous to clk.
REQ-009 SHALL have port pll_reset, output, 1: active-high PLL reset.
REQ-010 SHALL have port sys_rst_n, output, 1: active-low system reset.
REQ-011 SHALL have port ce, output, NUM_CE: per-channel one-cycle enable pulses.
REQ-012 SHALL have port state_o, output, 2: current FSM state.
REQ-013 SHALL have port lock_lost, output, 1: one-cycle pulse on lock loss in RUN.

Function
REQ-014 SHALL synchronise pll_lock through two flops; lock_s (second flop) is the only internal view.
REQ-015 SHALL implement states WAIT_LOCK=0, PLL_RST=1, STABILIZE=2, RUN=3.
REQ-016 WAIT_LOCK: timeout counter increments each cycle; lock_s=1 -> STABILIZE, counter cleared; counter = LOCK_TIMEOUT_CYCLES-1 with lock_s=0 -> PLL_RST.
REQ-017 Lock and timeout in the same cycle SHALL resolve to STABILIZE.
REQ-018 PLL_RST: pll_reset=1 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK with timeout counter cleared; lock_s ignored.
REQ-019 STABILIZE: lock_s=0 on any cycle -> WAIT_LOCK; after LOCK_STABLE_CYCLES consecutive lock_s=1 cycles -> RUN.
REQ-020 sys_rst_n SHALL be registered, 1 only in RUN, rising on the clock edge that enters RUN.
REQ-021 pll_lock held high from edge N (first sampling edge) SHALL give sys_rst_n=1 at edge N+1+LOCK_STABLE_CYCLES+1.
REQ-022 RUN: lock_s=0 -> WAIT_LOCK; on that edge sys_rst_n=0, lock_lost=1 for one cycle, all ce=0.
REQ-023 Channel i SHALL have an independent 16-bit counter held at 0 outside RUN; in RUN ce[i]=1 for one cycle each time the counter reaches (CE_DIV_BASE<<i)-1, then wraps to 0.
REQ-024 First ce[i] pulse SHALL occur CE_DIV_BASE<<i cycles after RUN entry; all channels coincide then and at every multiple of the largest divisor.
REQ-025 ce, lock_lost, pll_reset SHALL be registered outputs (no combinational path from pll_lock).

Reset
REQ-026 rst_n=0 SHALL asynchronously force: state WAIT_LOCK, sys_rst_n=0, pll_reset=0, ce=0, lock_lost=0, sync flops=0, all counters=0.
REQ-027 rst_n deassertion mid-PLL_RST SHALL restart from WAIT_LOCK with pll_reset=0; no residual pulse.

Configuration
REQ-028 Macro CLK_RST_MGR_STATUS_EN defined: SHALL add outputs retry_cnt[7:0] (increments on each PLL_RST entry) and lost_cnt[7:0] (increments on each lock_lost), both saturating at 255, cleared only by rst_n.
REQ-029 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-030 Package clk_rst_pkg SHALL hold the state encoding constants and CE counter width (16).
REQ-031 Sub-module clk_rst_ce_div SHALL implement one channel (parameter DIV, inputs clk, rst_n, run; output ce), instanced NUM_CE times via generate.

Verification
REQ-032 pll_lock high 10 cycles after reset, LOCK_STABLE_CYCLES=8 -> sys_rst_n rises exactly 10 edges after first sampling edge; state_o 0->2->3.
REQ-033 pll_lock never high, LOCK_TIMEOUT_CYCLES=100, PLL_RST_CYCLES=16 -> pll_reset 16-cycle pulses every 116 cycles; retry_cnt 1,2,3 (macro on).
REQ-034 Lock glitches low 1 cycle mid-STABILIZE -> return to WAIT_LOCK, stable count restarts, sys_rst_n stays 0.
REQ-035 Lock drops in RUN -> lock_lost single pulse, sys_rst_n=0 and ce=0 same edge, lost_cnt=1.
REQ-036 RUN with defaults -> ce[0] every 2, ce[1] every 4, ce[2] every 8 cycles, first pulses 2/4/8 cycles after entry.
